// File: rtl/axi_pkg.sv
// Shared encodings and helpers for the AXI4 to AXI4-Lite burst splitter.
// Burst/resp codes, FSM state set and response merging.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RD_OUT,
        WR_DATA_IN,
        WR_ISSUE,
        WR_RESP,
        WR_OUT
    } state_e;

    // Worst-of merge: the numerically larger code is the more severe one.
    function automatic logic [1:0] max_resp(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_lite_splitter_if.sv
// Bus bundles for the splitter: full AXI4 on the crossbar side and
// AXI4-Lite on the peripheral side, each with master/slave views.
interface axi4_full_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;

    logic                  b_valid;
    logic                  b_ready;
    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;

    logic                  r_valid;
    logic                  r_ready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

interface axi_lite_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;

    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport master (
        output aw_valid, aw_addr,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr,
        input  ar_ready,
        input  r_valid, r_data, r_resp,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr,
        output ar_ready,
        output r_valid, r_data, r_resp,
        input  r_ready
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Reserved burst encoding falls back to INCR behaviour.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    // Wide enough that (len+1) << size never overflows.
    localparam int W = ADDR_WIDTH + 16;

    logic [W-1:0] wide_addr;
    logic [W-1:0] step;
    logic [W-1:0] wrap_bytes;
    logic [W-1:0] mask;
    logic [W-1:0] incr;
    logic [W-1:0] base;

    always_comb begin
        wide_addr  = W'(addr);
        step       = W'(1) << size;
        wrap_bytes = W'({1'b0, len} + 9'd1) << size;
        mask       = wrap_bytes - W'(1);
        incr       = wide_addr + step;
        base       = wide_addr & ~mask;
        next_addr  = addr;
        unique case (burst_e'(burst))
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = ADDR_WIDTH'(base | (incr & mask));
            default:     next_addr = ADDR_WIDTH'(incr);
        endcase
    end

endmodule

// File: rtl/axi4_lite_splitter.sv
// Unrolls AXI4 bursts into single-beat AXI4-Lite accesses, one transaction
// at a time, with round-robin arbitration between reads and writes.
module axi4_lite_splitter
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    axi4_full_if.slave s,
    axi_lite_if.master m
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e state_q;
    state_e state_d;

    logic                  last_wr_q;
    logic                  aw_rdy_q;
    logic                  ar_rdy_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done_q;
    logic                  w_done_q;

    logic                  ar_hs;
    logic                  aw_hs;
    logic                  is_last;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign ar_hs   = s.ar_valid && ar_rdy_q;
    assign aw_hs   = s.aw_valid && aw_rdy_q;
    assign is_last = (beat_q == len_q);

    axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .addr     (addr_q),
        .size     (size_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_addr(next_addr)
    );

    // Every output is a register or a pure decode of registered state.
    assign s.aw_ready = aw_rdy_q;
    assign s.ar_ready = ar_rdy_q;
    assign s.w_ready  = (state_q == WR_DATA_IN);
    assign s.b_valid  = (state_q == WR_OUT);
    assign s.b_id     = id_q;
    assign s.b_resp   = err_q;
    assign s.r_valid  = (state_q == RD_OUT);
    assign s.r_id     = id_q;
    assign s.r_data   = rdata_q;
    assign s.r_resp   = rresp_q;
    assign s.r_last   = rlast_q;

    assign m.ar_valid = (state_q == RD_ADDR);
    assign m.ar_addr  = addr_q;
    assign m.r_ready  = (state_q == RD_DATA);
    assign m.aw_valid = (state_q == WR_ISSUE) && !aw_done_q;
    assign m.aw_addr  = addr_q;
    assign m.w_valid  = (state_q == WR_ISSUE) && !w_done_q;
    assign m.w_data   = wdata_q;
    assign m.w_strb   = wstrb_q;
    assign m.b_ready  = (state_q == WR_RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ar_hs)      state_d = RD_ADDR;
                else if (aw_hs) state_d = WR_DATA_IN;
            end
            RD_ADDR:
                if (m.ar_ready) state_d = RD_DATA;
            RD_DATA:
                if (m.r_valid) state_d = RD_OUT;
            RD_OUT:
                if (s.r_ready) state_d = is_last ? IDLE : RD_ADDR;
            WR_DATA_IN:
                if (s.w_valid) state_d = WR_ISSUE;
            WR_ISSUE:
                if (aw_done_q && w_done_q) state_d = WR_RESP;
            WR_RESP:
                if (m.b_valid) state_d = is_last ? WR_OUT : WR_DATA_IN;
            WR_OUT:
                if (s.b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_wr_q <= 1'b1;
            aw_rdy_q  <= 1'b0;
            ar_rdy_q  <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            // Grant is registered: a ready rises the cycle after valid is seen.
            if (state_q == IDLE && !aw_rdy_q && !ar_rdy_q) begin
                if (s.ar_valid && (!s.aw_valid || last_wr_q))
                    ar_rdy_q <= 1'b1;
                else if (s.aw_valid)
                    aw_rdy_q <= 1'b1;
            end
            if (ar_hs) begin
                ar_rdy_q  <= 1'b0;
                last_wr_q <= 1'b0;
                id_q      <= s.ar_id;
                addr_q    <= s.ar_addr;
                len_q     <= s.ar_len;
                size_q    <= s.ar_size;
                burst_q   <= s.ar_burst;
                beat_q    <= '0;
                err_q     <= RESP_OKAY;
            end
            if (aw_hs) begin
                aw_rdy_q  <= 1'b0;
                last_wr_q <= 1'b1;
                id_q      <= s.aw_id;
                addr_q    <= s.aw_addr;
                len_q     <= s.aw_len;
                size_q    <= s.aw_size;
                burst_q   <= s.aw_burst;
                beat_q    <= '0;
                err_q     <= RESP_OKAY;
            end

            if (state_q == RD_DATA && m.r_valid) begin
                rdata_q <= m.r_data;
                rresp_q <= m.r_resp;
                rlast_q <= is_last;
            end
            if (state_q == RD_OUT && s.r_ready && !is_last) begin
                addr_q <= next_addr;
                beat_q <= beat_q + 8'd1;
            end

            if (state_q == WR_DATA_IN && s.w_valid) begin
                wdata_q   <= s.w_data;
                wstrb_q   <= s.w_strb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                // Beat count stays authoritative; a bad w_last only flags.
                if (s.w_last != is_last)
                    err_q <= max_resp(err_q, RESP_SLVERR);
            end
            if (state_q == WR_ISSUE) begin
                if (m.aw_valid && m.aw_ready) aw_done_q <= 1'b1;
                if (m.w_valid && m.w_ready)   w_done_q  <= 1'b1;
            end
            if (state_q == WR_RESP && m.b_valid) begin
                err_q <= max_resp(err_q, m.b_resp);
                if (!is_last) begin
                    addr_q <= next_addr;
                    beat_q <= beat_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_splitter.sv
// Directed bench for axi4_lite_splitter with a scoreboard of expected beats
// and a reactive AXI-Lite slave model with optional back-pressure.
module tb_axi4_lite_splitter;
    import axi_pkg::*;

    localparam int IW = 4;
    localparam int AW = 13;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi4_full_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s();
    axi_lite_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m();

    axi4_lite_splitter #(
        .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s    (s),
        .m    (m)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    int total = 0;
    int bad   = 0;
    bit bp    = 1'b0;
    int r_beats = 0;

    r_exp_t        exp_r[$];
    b_exp_t        exp_b[$];
    logic [AW-1:0] exp_ar[$];
    logic [AW-1:0] exp_aw[$];
    logic [35:0]   exp_w[$];
    logic [1:0]    slv_bresp[$];
    logic [AW-1:0] ar_seen[$];
    int            order_log[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return DW'({a - AW'(4), 8'hA5});
    endfunction

    function automatic logic [AW-1:0] next_a(input logic [AW-1:0] a,
        input int size, input int len, input logic [1:0] burst);
        int step  = 1 << size;
        int bytes = (len + 1) * step;
        int ai    = int'(a);
        if (burst == 2'd0) return a;
        if (burst == 2'd2)
            return AW'(ai - (ai % bytes) + ((ai % bytes + step) % bytes));
        return AW'(ai + step);
    endfunction

    // AXI-Lite slave model: sample at negedge, react just after posedge.
    initial begin : lite_slave
        bit har, hr, haw, hw, hb, rst_now, r_pend, aw_got, w_got;
        logic [AW-1:0] a_ar, a_aw;
        logic [35:0]   wv;
        logic [DW-1:0] r_dat;
        r_pend = 0; aw_got = 0; w_got = 0; r_dat = '0;
        m.ar_ready = 0; m.r_valid = 0; m.r_data = '0; m.r_resp = '0;
        m.aw_ready = 0; m.w_ready = 0; m.b_valid = 0; m.b_resp = '0;
        forever begin
            @(negedge clock);
            rst_now = reset;
            har  = m.ar_valid && m.ar_ready;
            hr   = m.r_valid && m.r_ready;
            haw  = m.aw_valid && m.aw_ready;
            hw   = m.w_valid && m.w_ready;
            hb   = m.b_valid && m.b_ready;
            a_ar = m.ar_addr;
            a_aw = m.aw_addr;
            wv   = {m.w_strb, m.w_data};
            @(posedge clock); #1;
            if (rst_now) begin
                r_pend = 0; aw_got = 0; w_got = 0;
                m.r_valid = 0; m.b_valid = 0;
                m.ar_ready = 0; m.aw_ready = 0; m.w_ready = 0;
                continue;
            end
            if (har) begin
                ar_seen.push_back(a_ar);
                chk("ar_pending", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) chk("m_ar_addr", a_ar, exp_ar.pop_front());
                r_pend = 1;
                r_dat  = rdata(a_ar);
            end
            if (hr) m.r_valid = 0;
            if (r_pend && !m.r_valid && (!bp || $urandom_range(0, 1) == 1)) begin
                m.r_valid = 1; m.r_data = r_dat; m.r_resp = RESP_OKAY; r_pend = 0;
            end
            if (haw) begin
                chk("aw_pending", exp_aw.size() > 0, 1);
                if (exp_aw.size() > 0) chk("m_aw_addr", a_aw, exp_aw.pop_front());
                aw_got = 1;
            end
            if (hw) begin
                chk("w_pending", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) chk("m_w_strb_data", wv, exp_w.pop_front());
                w_got = 1;
            end
            if (hb) m.b_valid = 0;
            if (aw_got && w_got && !m.b_valid && (!bp || $urandom_range(0, 1) == 1)) begin
                m.b_valid = 1;
                m.b_resp  = (slv_bresp.size() > 0) ? slv_bresp.pop_front() : RESP_OKAY;
                aw_got = 0; w_got = 0;
            end
            m.ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m.aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m.w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : r_mon
        r_exp_t e;
        s.r_ready = 0;
        forever begin
            @(negedge clock);
            if (!reset && s.r_valid && s.r_ready) begin
                r_beats++;
                chk("r_pending", exp_r.size() > 0, 1);
                if (exp_r.size() > 0) begin
                    e = exp_r.pop_front();
                    chk("r_id", s.r_id, e.id);
                    chk("r_data", s.r_data, e.data);
                    chk("r_resp", s.r_resp, e.resp);
                    chk("r_last", s.r_last, e.last);
                end
            end
            @(posedge clock); #1;
            s.r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : b_mon
        b_exp_t e;
        s.b_ready = 0;
        forever begin
            @(negedge clock);
            if (!reset && s.b_valid && s.b_ready) begin
                chk("b_pending", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    chk("b_id", s.b_id, e.id);
                    chk("b_resp", s.b_resp, e.resp);
                end
            end
            @(posedge clock); #1;
            s.b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic expect_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
        input int len, input int size, input logic [1:0] burst);
        logic [AW-1:0] a = addr;
        r_exp_t e;
        for (int b = 0; b <= len; b++) begin
            exp_ar.push_back(a);
            e.id = id; e.data = rdata(a); e.resp = RESP_OKAY; e.last = (b == len);
            exp_r.push_back(e);
            a = next_a(a, size, len, burst);
        end
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
        input int len, input int size, input logic [1:0] burst);
        bit hs = 0;
        s.ar_valid = 1; s.ar_id = id; s.ar_addr = addr;
        s.ar_len = 8'(len); s.ar_size = 3'(size); s.ar_burst = burst;
        for (int n = 0; n < 3000 && !hs; n++) begin
            @(negedge clock); hs = s.ar_ready;
            @(posedge clock); #1;
        end
        s.ar_valid = 0;
        chk("ar_accepted", hs, 1);
        order_log.push_back(1);
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
        input int len, input int size, input logic [1:0] burst);
        expect_read(id, addr, len, size, burst);
        send_ar(id, addr, len, size, burst);
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
        input int len, input int size, input logic [1:0] burst,
        input int badlast, input int slv_beat, input logic [1:0] slv_val);
        logic [AW-1:0] a = addr;
        logic [1:0]    err = RESP_OKAY;
        logic [1:0]    r;
        logic [35:0]   wq[$];
        b_exp_t        e;
        bit            hs = 0;
        for (int b = 0; b <= len; b++) begin
            exp_aw.push_back(a);
            wq.push_back({4'(4'h1 << (b % 4)) | 4'h8, 32'hD000_0000 | (32'(a) << 8) | 32'(b)});
            exp_w.push_back(wq[b]);
            r = (b == slv_beat) ? slv_val : RESP_OKAY;
            slv_bresp.push_back(r);
            if (b == badlast && err < RESP_SLVERR) err = RESP_SLVERR;
            if (r > err) err = r;
            a = next_a(a, size, len, burst);
        end
        e.id = id; e.resp = err;
        exp_b.push_back(e);
        s.aw_valid = 1; s.aw_id = id; s.aw_addr = addr;
        s.aw_len = 8'(len); s.aw_size = 3'(size); s.aw_burst = burst;
        for (int n = 0; n < 3000 && !hs; n++) begin
            @(negedge clock); hs = s.aw_ready;
            @(posedge clock); #1;
        end
        s.aw_valid = 0;
        chk("aw_accepted", hs, 1);
        order_log.push_back(2);
        for (int b = 0; b <= len; b++) begin
            hs = 0;
            s.w_valid = 1; s.w_strb = wq[b][35:32]; s.w_data = wq[b][31:0];
            s.w_last  = (b == len) ^ (b == badlast);
            for (int n = 0; n < 3000 && !hs; n++) begin
                @(negedge clock); hs = s.w_ready;
                @(posedge clock); #1;
            end
            s.w_valid = 0;
            chk("w_accepted", hs, 1);
        end
    endtask

    task automatic wait_drain(input string tag);
        bit done = 0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(posedge clock); #1;
            done = exp_r.size() == 0 && exp_b.size() == 0 &&
                   exp_ar.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0;
        end
        chk(tag, done, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int start;
        bit seen;
        s.aw_valid = 0; s.aw_id = '0; s.aw_addr = '0; s.aw_len = '0;
        s.aw_size = '0; s.aw_burst = '0;
        s.w_valid = 0; s.w_data = '0; s.w_strb = '0; s.w_last = 0;
        s.ar_valid = 0; s.ar_id = '0; s.ar_addr = '0; s.ar_len = '0;
        s.ar_size = '0; s.ar_burst = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_s_ready", {s.aw_ready, s.ar_ready, s.w_ready}, 0);
        chk("rst_s_valid", {s.b_valid, s.r_valid}, 0);
        chk("rst_m_valid", {m.ar_valid, m.aw_valid, m.w_valid}, 0);
        chk("rst_m_ready", {m.r_ready, m.b_ready}, 0);
        chk("rst_r_payload", {s.r_id, s.r_data, s.r_resp, s.r_last}, 0);
        chk("rst_b_payload", {s.b_id, s.b_resp}, 0);
        reset = 0;
        @(posedge clock); #1;

        do_read(4'd3, 13'h004, 0, 2, BURST_INCR);
        wait_drain("drain_single_read");

        do_read(4'd4, 13'h010, 3, 2, BURST_INCR);
        wait_drain("drain_incr_read");

        ar_seen.delete();
        do_read(4'd5, 13'h018, 3, 2, BURST_WRAP);
        wait_drain("drain_wrap_read");
        chk("wrap_beats", ar_seen.size(), 4);
        chk("wrap_a0", ar_seen[0], 13'h018);
        chk("wrap_a1", ar_seen[1], 13'h01C);
        chk("wrap_a2", ar_seen[2], 13'h010);
        chk("wrap_a3", ar_seen[3], 13'h014);

        do_write(4'd5, 13'h100, 2, 2, BURST_INCR, -1, 1, RESP_SLVERR);
        wait_drain("drain_write_slverr");
        do_write(4'd6, 13'h120, 1, 2, BURST_INCR, 0, -1, RESP_OKAY);
        wait_drain("drain_write_badlast");
        do_write(4'd1, 13'h020, 0, 2, BURST_INCR, -1, 0, RESP_DECERR);
        wait_drain("drain_write_decerr");

        bp = 1;
        order_log.delete();
        for (int k = 0; k < 2; k++) begin
            fork
                begin
                    if (k == 0) do_read(4'd6, 13'h200, 3, 2, BURST_INCR);
                    else        do_read(4'd8, 13'h038, 1, 2, BURST_RSVD);
                end
                begin
                    if (k == 0) do_write(4'd7, 13'h300, 1, 2, BURST_INCR, -1, -1, RESP_OKAY);
                    else        do_write(4'd2, 13'h040, 2, 2, BURST_FIXED, -1, 2, RESP_EXOKAY);
                end
            join
        end
        wait_drain("drain_tie_bp");
        chk("grant_count", order_log.size(), 4);
        chk("grant0", order_log[0], 1);
        chk("grant1", order_log[1], 2);
        chk("grant2", order_log[2], 1);
        chk("grant3", order_log[3], 2);
        bp = 0;

        start = r_beats;
        expect_read(4'd9, 13'h040, 7, 2, BURST_INCR);
        send_ar(4'd9, 13'h040, 7, 2, BURST_INCR);
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clock); #1;
            seen = (r_beats == start + 1) && m.ar_valid;
        end
        chk("reach_beat2", seen, 1);
        reset = 1;
        #1;
        chk("midrst_valids", {m.ar_valid, m.aw_valid, m.w_valid,
                              s.r_valid, s.b_valid}, 0);
        chk("midrst_readies", {s.aw_ready, s.ar_ready, s.w_ready,
                               m.r_ready, m.b_ready}, 0);
        exp_r.delete();
        exp_ar.delete();
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        @(posedge clock); #1;
        chk("post_rst_beats", r_beats, start + 1);

        do_read(4'd10, 13'h008, 0, 2, BURST_INCR);
        wait_drain("drain_after_reset");

        chk("final_queues", exp_r.size() + exp_b.size() + exp_ar.size() +
                            exp_aw.size() + exp_w.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
